// File: rtl/enc8b10b_pkg.sv
// Shared constants and the legal-K-code check for the multilane 8b/10b encoder.
package enc8b10b_pkg;

  localparam int unsigned MAX_LANES = 8;

  localparam logic [7:0] K28_5  = 8'hBC;
  localparam logic       RD_NEG = 1'b0;
  localparam logic       RD_POS = 1'b1;

  // K28.y for any y, plus K23.7 / K27.7 / K29.7 / K30.7
  function automatic logic is_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) ||
           ((b[7:5] == 3'd7) &&
            ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
             (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
  endfunction

endpackage

// File: rtl/enc_8b10b_lane.sv
// Single-byte combinational 8b/10b encoder (5b/6b + 3b/4b) with disparity in/out.
module enc_8b10b_lane
  import enc8b10b_pkg::*;
(
  input  logic [7:0] din,
  input  logic       kin,
  input  logic       rd_in,
  output logic [9:0] code_c,
  output logic       rd_c,
  output logic       kerr_c
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] t6;      // abcdei, a in bit 5, RD- column
  logic [5:0] t6f;
  logic [3:0] t4;      // fghj, f in bit 3, RD- column
  logic [3:0] t4f;
  logic       unbal6;
  logic       comp6;
  logic       comp4;
  logic       rd_mid;
  logic       a7;

  // Table lookup for the RD- column, complement for RD+ where the code is not self-paired
  always_comb begin
    x      = din[4:0];
    y      = din[7:5];
    t6     = 6'b000000;
    t4     = 4'b0000;
    a7     = 1'b0;
    comp4  = 1'b0;

    if (kin && (x == 5'd28)) begin
      t6 = 6'b001111;
    end else begin
      case (x)
        5'd0:  t6 = 6'b100111;
        5'd1:  t6 = 6'b011101;
        5'd2:  t6 = 6'b101101;
        5'd3:  t6 = 6'b110001;
        5'd4:  t6 = 6'b110101;
        5'd5:  t6 = 6'b101001;
        5'd6:  t6 = 6'b011001;
        5'd7:  t6 = 6'b111000;
        5'd8:  t6 = 6'b111001;
        5'd9:  t6 = 6'b100101;
        5'd10: t6 = 6'b010101;
        5'd11: t6 = 6'b110100;
        5'd12: t6 = 6'b001101;
        5'd13: t6 = 6'b101100;
        5'd14: t6 = 6'b011100;
        5'd15: t6 = 6'b010111;
        5'd16: t6 = 6'b011011;
        5'd17: t6 = 6'b100011;
        5'd18: t6 = 6'b010011;
        5'd19: t6 = 6'b110010;
        5'd20: t6 = 6'b001011;
        5'd21: t6 = 6'b101010;
        5'd22: t6 = 6'b011010;
        5'd23: t6 = 6'b111010;
        5'd24: t6 = 6'b110011;
        5'd25: t6 = 6'b100110;
        5'd26: t6 = 6'b010110;
        5'd27: t6 = 6'b110110;
        5'd28: t6 = 6'b001110;
        5'd29: t6 = 6'b101110;
        5'd30: t6 = 6'b011110;
        default: t6 = 6'b101011;
      endcase
    end

    // D.7 is balanced but still alternates between 111000 and 000111
    unbal6 = ($countones(t6) != 3);
    comp6  = rd_in & (unbal6 | (x == 5'd7));
    t6f    = comp6 ? ~t6 : t6;
    rd_mid = rd_in ^ unbal6;

    if (kin) begin
      case (y)
        3'd0: t4 = 4'b1011;
        3'd1: t4 = 4'b0110;
        3'd2: t4 = 4'b1010;
        3'd3: t4 = 4'b1100;
        3'd4: t4 = 4'b1101;
        3'd5: t4 = 4'b0101;
        3'd6: t4 = 4'b1001;
        default: t4 = 4'b0111;
      endcase
      comp4 = rd_mid;
    end else begin
      // A7 avoids a run of five identical bits across the 6b/4b boundary
      a7 = (y == 3'd7) &&
           ((!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
            ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
      case (y)
        3'd0: t4 = 4'b1011;
        3'd1: t4 = 4'b1001;
        3'd2: t4 = 4'b0101;
        3'd3: t4 = 4'b1100;
        3'd4: t4 = 4'b1101;
        3'd5: t4 = 4'b1010;
        3'd6: t4 = 4'b0110;
        default: t4 = a7 ? 4'b0111 : 4'b1110;
      endcase
      comp4 = rd_mid & ((y == 3'd0) | (y == 3'd3) | (y == 3'd4) | (y == 3'd7));
    end

    t4f    = comp4 ? ~t4 : t4;
    rd_c   = rd_mid ^ ($countones(t4) != 2);
    code_c = {t4f[0], t4f[1], t4f[2], t4f[3],
              t6f[0], t6f[1], t6f[2], t6f[3], t6f[4], t6f[5]};
    kerr_c = kin & !is_legal_k(din);
  end

endmodule

// File: rtl/enc_8b10b_multilane.sv
// Registered multilane 8b/10b encoder with disparity chained across lanes and words.
// Optional idle fill (K28.5 words when no input is offered): define ENC_IDLE_FILL_EN.
module enc_8b10b_multilane
  import enc8b10b_pkg::*;
#(
  parameter int unsigned LANES   = 2,
  parameter logic        RD_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*LANES-1:0]    in_data,
  input  logic [LANES-1:0]      in_k,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  rd_clr,
  output logic [10*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_kerr,
  output logic                  out_idle,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  rd_out
);

  localparam int unsigned DW = 8 * LANES;
  localparam int unsigned CW = 10 * LANES;

  if ((LANES < 1) || (LANES > MAX_LANES)) begin : g_lanes_check
    $error("enc_8b10b_multilane: LANES must be 1..8");
  end

  logic [LANES:0]   rd_chain;
  logic [DW-1:0]    lane_data;
  logic [LANES-1:0] lane_k;
  logic [CW-1:0]    enc_data;
  logic [LANES-1:0] enc_kerr;
  logic             fill;
  logic             load;
  logic             rd_q;

  assign in_ready = !out_valid | out_ready;

`ifdef ENC_IDLE_FILL_EN
  assign fill = in_ready & !in_valid;
`else
  assign fill = 1'b0;
`endif

  assign load        = in_ready & (in_valid | fill);
  assign lane_data   = fill ? {LANES{K28_5}} : in_data;
  assign lane_k      = fill ? {LANES{1'b1}} : in_k;
  assign rd_chain[0] = rd_clr ? RD_INIT : rd_q;
  assign rd_out      = rd_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    enc_8b10b_lane u_lane (
      .din    (lane_data[8*g +: 8]),
      .kin    (lane_k[g]),
      .rd_in  (rd_chain[g]),
      .code_c (enc_data[10*g +: 10]),
      .rd_c   (rd_chain[g+1]),
      .kerr_c (enc_kerr[g])
    );
  end

  // Output register, handshake and running-disparity state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_kerr  <= '0;
      out_idle  <= 1'b0;
      rd_q      <= RD_INIT;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= enc_data;
      out_kerr  <= fill ? '0 : enc_kerr;
      out_idle  <= fill;
      rd_q      <= rd_chain[LANES];
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (rd_clr)    rd_q      <= RD_INIT;
    end
  end

endmodule

// File: tb/tb_enc_8b10b_multilane.sv
// Self-checking bench: directed checks on a 1-lane instance, scoreboard on a 2-lane instance.
module tb_enc_8b10b_multilane;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  // 1-lane instance
  logic [7:0] i1_data;
  logic       i1_k, i1_valid, i1_ready, rd1_clr;
  logic [9:0] o1_data;
  logic       o1_kerr, o1_idle, o1_valid, o1_ready, rd1_out;

  // 2-lane instance
  logic [15:0] i2_data;
  logic [1:0]  i2_k;
  logic        i2_valid, i2_ready, rd2_clr;
  logic [19:0] o2_data;
  logic [1:0]  o2_kerr;
  logic        o2_idle, o2_valid, o2_ready, rd2_out;

  enc_8b10b_multilane #(.LANES(1), .RD_INIT(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(i1_data), .in_k(i1_k), .in_valid(i1_valid),
    .in_ready(i1_ready), .rd_clr(rd1_clr), .out_data(o1_data), .out_kerr(o1_kerr),
    .out_idle(o1_idle), .out_valid(o1_valid), .out_ready(o1_ready), .rd_out(rd1_out));

  enc_8b10b_multilane #(.LANES(2), .RD_INIT(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(i2_data), .in_k(i2_k), .in_valid(i2_valid),
    .in_ready(i2_ready), .rd_clr(rd2_clr), .out_data(o2_data), .out_kerr(o2_kerr),
    .out_idle(o2_idle), .out_valid(o2_valid), .out_ready(o2_ready), .rd_out(rd2_out));

  // Reference tables, abcdei with a in bit 5, written out for both disparity columns
  localparam logic [5:0] N6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] P6 [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] DN4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] DP4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] KN4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] KP4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

  // Returns {rd_after, code[9:0]} for one byte (legal K codes and data only)
  function automatic logic [10:0] ref_enc(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] t6;
    logic [3:0] t4;
    logic       rdm;
    logic       rdo;
    int         n6;
    int         n4;
    x = b[4:0];
    y = b[7:5];
    if (k && (x == 5'd28)) t6 = rd ? 6'b110000 : 6'b001111;
    else                   t6 = rd ? P6[x] : N6[x];
    n6  = $countones(t6);
    rdm = (n6 == 3) ? rd : (n6 > 3);
    if (k)                 t4 = rdm ? KP4[y] : KN4[y];
    else if (y == 3'd7) begin
      if (!rdm && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)))     t4 = 4'b0111;
      else if (rdm && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))) t4 = 4'b1000;
      else                                                            t4 = rdm ? 4'b0001 : 4'b1110;
    end else               t4 = rdm ? DP4[y] : DN4[y];
    n4  = $countones(t4);
    rdo = (n4 == 2) ? rdm : (n4 > 2);
    return {rdo, t4[0], t4[1], t4[2], t4[3], t6[0], t6[1], t6[2], t6[3], t6[4], t6[5]};
  endfunction

  function automatic logic legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE);
  endfunction

  // Scoreboard for the 2-lane instance
  typedef struct packed {
    logic [19:0] data;
    logic [1:0]  kerr;
    logic        clr;
  } exp_t;

  exp_t  sbq[$];
  exp_t  e_pop;
  exp_t  e_push;
  logic  m_rd2;
  logic  chk_rd;
  logic  pend_clr;
  logic  start_rd;
  logic  disp_ok;
  logic [10:0] r;
  logic [9:0]  c;
  int    nb;
  int    n_push = 0;
  int    n_pop  = 0;

  // Pop/compare outputs, track disparity, push expected words on accept
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      m_rd2    = 1'b0;
      chk_rd   = 1'b0;
      pend_clr = 1'b0;
    end else begin
      if (o2_valid && o2_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got word %h, expected no word", o2_data);
        end else begin
          e_pop = sbq.pop_front();
          n_pop++;
          if (o2_data !== e_pop.data || o2_kerr !== e_pop.kerr || o2_idle !== 1'b0) begin
            errors++;
            $display("FAIL sb_word: got data=%h kerr=%b idle=%b, expected data=%h kerr=%b idle=0",
                     o2_data, o2_kerr, o2_idle, e_pop.data, e_pop.kerr);
          end
          // Independent disparity-chain check from code weights alone
          if (e_pop.clr) chk_rd = 1'b0;
          disp_ok = 1'b1;
          for (int l = 0; l < 2; l++) begin
            c  = o2_data[10*l +: 10];
            nb = $countones(c[5:0]);
            if (!((nb == 3) || (nb == 4 && !chk_rd) || (nb == 2 && chk_rd))) disp_ok = 1'b0;
            if (nb != 3) chk_rd = (nb == 4);
            nb = $countones(c[9:6]);
            if (!((nb == 2) || (nb == 3 && !chk_rd) || (nb == 1 && chk_rd))) disp_ok = 1'b0;
            if (nb != 2) chk_rd = (nb == 3);
          end
          checks++;
          if (!disp_ok) begin
            errors++;
            $display("FAIL sb_disparity: word %h breaks running disparity", o2_data);
          end
        end
      end
      checks++;
      if (rd2_out !== m_rd2) begin
        errors++;
        $display("FAIL rd_out_lanes2: got %b, expected %b", rd2_out, m_rd2);
      end
      if (i2_valid && i2_ready) begin
        start_rd = rd2_clr ? 1'b0 : m_rd2;
        for (int l = 0; l < 2; l++) begin
          r = ref_enc(i2_data[8*l +: 8], i2_k[l], start_rd);
          e_push.data[10*l +: 10] = r[9:0];
          e_push.kerr[l] = i2_k[l] & !legal_k(i2_data[8*l +: 8]);
          start_rd = r[10];
        end
        e_push.clr = rd2_clr | pend_clr;
        pend_clr   = 1'b0;
        m_rd2      = start_rd;
        sbq.push_back(e_push);
        n_push++;
      end else if (rd2_clr) begin
        m_rd2    = 1'b0;
        pend_clr = 1'b1;
      end
    end
  end

  task automatic drive1(input logic [7:0] d, input logic k, input logic clr);
    i1_data  = d;
    i1_k     = k;
    i1_valid = 1'b1;
    rd1_clr  = clr;
    @(posedge clk); #1;
    i1_valid = 1'b0;
    rd1_clr  = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (o1_valid !== 1'b0 || o1_data !== 10'h000 || o1_kerr !== 1'b0 || o1_idle !== 1'b0 ||
        rd1_out !== 1'b0 || i1_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b d=%h k=%b i=%b rd=%b rdy=%b, expected 0 000 0 0 0 1",
               o1_valid, o1_data, o1_kerr, o1_idle, rd1_out, i1_ready);
    end
    checks++;
    if (o2_valid !== 1'b0 || o2_data !== 20'h0 || o2_kerr !== 2'b00 || rd2_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state2: got v=%b d=%h k=%b rd=%b, expected 0 00000 00 0",
               o2_valid, o2_data, o2_kerr, rd2_out);
    end
    // Pending word must be discarded by a mid-stream reset
    o1_ready = 1'b0;
    drive1(8'hBC, 1'b1, 1'b0);
    checks++;
    if (o1_valid !== 1'b1 || i1_ready !== 1'b0 || rd1_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_before_reset: got v=%b rdy=%b rd=%b, expected 1 0 1", o1_valid, i1_ready, rd1_out);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (o1_valid !== 1'b0 || o1_data !== 10'h000 || rd1_out !== 1'b0 || i1_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midstream: got v=%b d=%h rd=%b rdy=%b, expected 0 000 0 1",
               o1_valid, o1_data, rd1_out, i1_ready);
    end
    o1_ready = 1'b1;
  endtask

  task automatic test_d21_5;
    drive1(8'hB5, 1'b0, 1'b0);
    checks++;
    if (o1_valid !== 1'b1 || o1_data !== 10'h155 || rd1_out !== 1'b0) begin
      errors++;
      $display("FAIL d21_5: got v=%b d=%h rd=%b, expected 1 155 0", o1_valid, o1_data, rd1_out);
    end
  endtask

  task automatic test_d0_0;
    drive1(8'h00, 1'b0, 1'b0);
    checks++;
    if (o1_data !== 10'h0B9 || rd1_out !== 1'b0) begin
      errors++;
      $display("FAIL d0_0: got d=%h rd=%b, expected 0b9 0", o1_data, rd1_out);
    end
    @(posedge clk); #1;
    checks++;
    if (o1_valid !== 1'b0 || o1_data !== 10'h0B9) begin
      errors++;
      $display("FAIL drain_hold: got v=%b d=%h, expected 0 0b9", o1_valid, o1_data);
    end
  endtask

  task automatic test_k28_rdclr;
    logic [9:0] ec [4];
    logic       er [4];
    logic       cl [4];
    ec[0] = 10'h17C; er[0] = 1'b1; cl[0] = 1'b0;
    ec[1] = 10'h283; er[1] = 1'b0; cl[1] = 1'b0;
    ec[2] = 10'h17C; er[2] = 1'b1; cl[2] = 1'b0;
    ec[3] = 10'h17C; er[3] = 1'b1; cl[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive1(8'hBC, 1'b1, cl[i]);
      checks++;
      if (o1_data !== ec[i] || rd1_out !== er[i] || o1_kerr !== 1'b0) begin
        errors++;
        $display("FAIL k28_5_%0d: got d=%h rd=%b kerr=%b, expected %h %b 0",
                 i, o1_data, rd1_out, o1_kerr, ec[i], er[i]);
      end
    end
    rd1_clr = 1'b1;
    @(posedge clk); #1;
    rd1_clr = 1'b0;
    checks++;
    if (rd1_out !== 1'b0) begin
      errors++;
      $display("FAIL rd_clr_alone: got rd=%b, expected 0", rd1_out);
    end
  endtask

  task automatic test_kerr;
    drive1(8'h00, 1'b1, 1'b0);
    checks++;
    if (o1_kerr !== 1'b1) begin
      errors++;
      $display("FAIL kerr_k0_0: got %b, expected 1", o1_kerr);
    end
    drive1(8'hB5, 1'b0, 1'b0);
    checks++;
    if (o1_kerr !== 1'b0) begin
      errors++;
      $display("FAIL kerr_next_data: got %b, expected 0", o1_kerr);
    end
    drive1(8'hF7, 1'b1, 1'b0);
    checks++;
    if (o1_kerr !== 1'b0) begin
      errors++;
      $display("FAIL kerr_k23_7: got %b, expected 0", o1_kerr);
    end
  endtask

  task automatic test_bcbc;
    o2_ready = 1'b1;
    i2_data  = 16'hBCBC;
    i2_k     = 2'b11;
    i2_valid = 1'b1;
    @(posedge clk); #1;
    i2_valid = 1'b0;
    checks++;
    if (o2_data !== {10'h283, 10'h17C} || rd2_out !== 1'b0 || o2_kerr !== 2'b00) begin
      errors++;
      $display("FAIL k28_5_pair: got d=%h rd=%b kerr=%b, expected a0d7c 0 00", o2_data, rd2_out, o2_kerr);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp_d;
    logic        rd;
    logic [10:0] rr;
    @(posedge clk); #1;
    rd = m_rd2;
    o2_ready = 1'b0;
    i2_data  = 16'h4A07;
    i2_k     = 2'b00;
    i2_valid = 1'b1;
    rr = ref_enc(8'h07, 1'b0, rd);
    exp_d[9:0] = rr[9:0];
    rr = ref_enc(8'h4A, 1'b0, rr[10]);
    exp_d[19:10] = rr[9:0];
    rd = rr[10];
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      i2_data = 16'h1111 * 16'(i + 1);
      checks++;
      if (i2_ready !== 1'b0 || o2_valid !== 1'b1 || o2_data !== exp_d || rd2_out !== rd) begin
        errors++;
        $display("FAIL stall_%0d: got rdy=%b v=%b d=%h rd=%b, expected 0 1 %h %b",
                 i, i2_ready, o2_valid, o2_data, rd2_out, exp_d, rd);
      end
      @(posedge clk); #1;
    end
    o2_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i2_data = 16'($urandom);
      @(posedge clk); #1;
    end
    i2_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int idx;
    logic [7:0] b;
    for (int n = 0; n < 10000; n++) begin
      i2_valid = ($urandom_range(0, 3) != 0);
      o2_ready = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < 2; l++) begin
        if ($urandom_range(0, 7) == 0) begin
          idx = $urandom_range(0, 11);
          case (idx)
            8:       b = 8'hF7;
            9:       b = 8'hFB;
            10:      b = 8'hFD;
            11:      b = 8'hFE;
            default: b = {3'(idx), 5'd28};
          endcase
          i2_data[8*l +: 8] = b;
          i2_k[l] = 1'b1;
        end else begin
          i2_data[8*l +: 8] = 8'($urandom);
          i2_k[l] = 1'b0;
        end
      end
      rd2_clr = ($urandom_range(0, 63) == 0) && (!o2_valid || o2_ready);
      @(posedge clk); #1;
    end
    i2_valid = 1'b0;
    rd2_clr  = 1'b0;
    o2_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0 || n_push != n_pop) begin
      errors++;
      $display("FAIL sb_drain: got pending=%0d pushed=%0d popped=%0d, expected 0 pending and equal counts",
               sbq.size(), n_push, n_pop);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    i1_data  = 8'h00; i1_k = 1'b0; i1_valid = 1'b0; rd1_clr = 1'b0; o1_ready = 1'b1;
    i2_data  = 16'h0; i2_k = 2'b00; i2_valid = 1'b0; rd2_clr = 1'b0; o2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_d21_5();
    test_d0_0();
    test_k28_rdclr();
    test_kerr();
    test_bcbc();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
